// File: rtl/uart_aes_pkg.sv
// Shared constants and types for the UART <-> AES command bridge.
// Optional CBC chaining is enabled by defining AES_CBC_EN.
package uart_aes_pkg;

  localparam logic [7:0] OP_KEY128 = 8'h4B;  // 'K'
  localparam logic [7:0] OP_KEY256 = 8'h4C;  // 'L'
  localparam logic [7:0] OP_ENC    = 8'h45;  // 'E'
  localparam logic [7:0] OP_DEC    = 8'h44;  // 'D'
  localparam logic [7:0] OP_IV     = 8'h49;  // 'I'

  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;
  localparam logic [7:0] TMO_DEF = 8'h18;

  typedef enum logic [2:0] {
    IDLE, COLLECT, AES_START, AES_WAIT_LO, AES_WAIT_HI, TX_LOAD, TX_PULSE, TX_WAIT
  } state_t;

  // Opcodes that open a payload-carrying frame
  function automatic logic op_known(input logic [7:0] op);
`ifdef AES_CBC_EN
    return (op == OP_KEY128) || (op == OP_KEY256) || (op == OP_ENC) ||
           (op == OP_DEC) || (op == OP_IV);
`else
    return (op == OP_KEY128) || (op == OP_KEY256) || (op == OP_ENC) || (op == OP_DEC);
`endif
  endfunction

endpackage

// File: rtl/uart_aes_txser.sv
// Byte serializer: shifts out up to 16 bytes MSB-first through the UART
// tx handshake. load_last is the index of the final byte (0 = one byte).
module uart_aes_txser
  import uart_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic [3:0]   load_last,
  input  logic         tx_busy,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  output logic         done
);

  state_t       st;
  logic [127:0] sh;
  logic [3:0]   rem;
  logic         guard;

  // Handshake FSM: present byte, request when tx idle, skip one guard cycle
  // so tx_busy has time to rise, then wait for the transmitter to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      sh       <= '0;
      rem      <= '0;
      guard    <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (st)
        IDLE: if (load) begin
          sh  <= load_data;
          rem <= load_last;
          st  <= TX_LOAD;
        end
        TX_LOAD: begin
          tx_data <= sh[127:120];
          st      <= TX_PULSE;
        end
        TX_PULSE: if (!tx_busy) begin
          tx_start <= 1'b1;
          guard    <= 1'b1;
          st       <= TX_WAIT;
        end
        TX_WAIT: begin
          if (guard) guard <= 1'b0;
          else if (!tx_busy) begin
            if (rem == 4'd0) begin
              done <= 1'b1;
              st   <= IDLE;
            end else begin
              sh  <= {sh[119:0], 8'h00};
              rem <= rem - 4'd1;
              st  <= TX_LOAD;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_aes_bridge.sv
// Framed UART command processor in front of an aes_core: key load (K/L),
// encrypt/decrypt (E/D), ACK/NAK/timeout status, sticky overrun flag.
// Define AES_CBC_EN to add the 'I' opcode and CBC chaining.
module uart_aes_bridge
  import uart_aes_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 5000000,
  parameter logic [7:0] ACK_BYTE     = ACK_DEF,
  parameter logic [7:0] NAK_BYTE     = NAK_DEF,
  parameter logic [7:0] TMO_BYTE     = TMO_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         aes_init,
  output logic         aes_next,
  output logic         aes_encdec,
  output logic         aes_keylen,
  output logic [255:0] aes_key,
  output logic [127:0] aes_block,
  input  logic         aes_ready,
  input  logic [127:0] aes_result,
  output logic         key_valid,
  output logic         overrun,
  output logic         busy
);

  state_t       st;
  logic [7:0]   op;
  logic [4:0]   cnt;
  logic [31:0]  tmo;
  logic [255:0] key_r;
  logic [127:0] blk_r;
  logic         tx_ld;
  logic [127:0] tx_word;
  logic [3:0]   tx_last;
  logic         tx_done;
  logic         is_key;
  logic [4:0]   last_idx;
  logic [127:0] resp;

  assign is_key   = (op == OP_KEY128) || (op == OP_KEY256);
  assign last_idx = (op == OP_KEY256) ? 5'd31 : 5'd15;
  assign busy     = (st != IDLE);
  assign aes_key  = key_r;

`ifdef AES_CBC_EN
  logic [127:0] chain;
  assign aes_block = (op == OP_ENC) ? (blk_r ^ chain) : blk_r;
  assign resp      = (op == OP_DEC) ? (aes_result ^ chain) : aes_result;
`else
  assign aes_block = blk_r;
  assign resp      = aes_result;
`endif

  // Frame FSM: collect payload, drive the core, hand the reply to txser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      op         <= '0;
      cnt        <= '0;
      tmo        <= '0;
      key_r      <= '0;
      blk_r      <= '0;
      key_valid  <= 1'b0;
      overrun    <= 1'b0;
      aes_init   <= 1'b0;
      aes_next   <= 1'b0;
      aes_encdec <= 1'b0;
      aes_keylen <= 1'b0;
      tx_ld      <= 1'b0;
      tx_word    <= '0;
      tx_last    <= '0;
`ifdef AES_CBC_EN
      chain      <= '0;
`endif
    end else begin
      aes_init <= 1'b0;
      aes_next <= 1'b0;
      tx_ld    <= 1'b0;
      if (rx_valid && (st != IDLE) && (st != COLLECT)) overrun <= 1'b1;
      case (st)
        IDLE: if (rx_valid) begin
          if (op_known(rx_data)) begin
            op  <= rx_data;
            cnt <= '0;
            tmo <= '0;
            st  <= COLLECT;
          end else begin
            tx_word <= {NAK_BYTE, 120'h0};
            tx_last <= 4'd0;
            tx_ld   <= 1'b1;
            st      <= TX_LOAD;
          end
        end
        COLLECT: begin
          // A byte on the expiry cycle wins over the timeout
          if (rx_valid) begin
            tmo <= '0;
            if (op == OP_KEY256)      key_r          <= {key_r[247:0], rx_data};
            else if (op == OP_KEY128) key_r[255:128] <= {key_r[247:128], rx_data};
            else                      blk_r          <= {blk_r[119:0], rx_data};
            if (cnt == last_idx) st <= AES_START;
            else                 cnt <= cnt + 5'd1;
          end else if ((TIMEOUT_CLKS != 0) && (tmo == 32'(TIMEOUT_CLKS - 1))) begin
            tx_word <= {TMO_BYTE, 120'h0};
            tx_last <= 4'd0;
            tx_ld   <= 1'b1;
            st      <= TX_LOAD;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        AES_START: begin
          if (is_key) begin
            if (aes_ready) begin
              aes_init   <= 1'b1;
              aes_keylen <= (op == OP_KEY256);
              key_valid  <= 1'b0;
              // 128-bit keys occupy the top half only
              if (op == OP_KEY128) key_r[127:0] <= '0;
              st <= AES_WAIT_LO;
            end
`ifdef AES_CBC_EN
          end else if (op == OP_IV) begin
            chain   <= blk_r;
            tx_word <= {ACK_BYTE, 120'h0};
            tx_last <= 4'd0;
            tx_ld   <= 1'b1;
            st      <= TX_LOAD;
`endif
          end else if (!key_valid) begin
            tx_word <= {NAK_BYTE, 120'h0};
            tx_last <= 4'd0;
            tx_ld   <= 1'b1;
            st      <= TX_LOAD;
          end else if (aes_ready) begin
            aes_next   <= 1'b1;
            aes_encdec <= (op == OP_ENC);
            st         <= AES_WAIT_LO;
          end
        end
        AES_WAIT_LO: if (!aes_ready) st <= AES_WAIT_HI;
        AES_WAIT_HI: if (aes_ready) begin
          tx_ld <= 1'b1;
          st    <= TX_LOAD;
          if (is_key) begin
            key_valid <= 1'b1;
            tx_word   <= {ACK_BYTE, 120'h0};
            tx_last   <= 4'd0;
`ifdef AES_CBC_EN
            chain     <= '0;
`endif
          end else begin
            tx_word <= resp;
            tx_last <= 4'd15;
`ifdef AES_CBC_EN
            chain   <= (op == OP_ENC) ? aes_result : blk_r;
`endif
          end
        end
        TX_LOAD: if (tx_done) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  uart_aes_txser u_txser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_ld),
    .load_data (tx_word),
    .load_last (tx_last),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .done      (tx_done)
  );

endmodule

// File: doc/uart_aes_bridge.md
Name: uart_aes_bridge

Overview:
Byte-stream command processor between the uart_rx/uart_tx byte interfaces and an external aes_core instance. It replaces the fixed-key, encrypt-only, free-running 16-byte collector with a framed protocol. Commands cover key loading (AES-128/256), encrypt and decrypt, with ACK/NAK status, inter-byte timeout and overrun detection. The top level wires rx_*/tx_* to the UART blocks and aes_* to aes_core.

Parameters:
TIMEOUT_CLKS, 5000000, clocks of rx silence mid-frame before the frame is abandoned (0 disables the timeout)
ACK_BYTE, 8'h06, status byte sent on success of K/L (and I, when compiled in)
NAK_BYTE, 8'h15, status byte sent on unknown opcode or on E/D with no key loaded
TMO_BYTE, 8'h18, status byte sent on timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy; rises the cycle after tx_start
aes_init  out  1  one-cycle key-expansion strobe
aes_next  out  1  one-cycle block-processing strobe
aes_encdec  out  1  1 = encrypt, 0 = decrypt
aes_keylen  out  1  0 = 128-bit key, 1 = 256-bit key
aes_key  out  256  key; a 128-bit key sits in [255:128], [127:0] = 0
aes_block  out  128  input block; the first received byte goes to [127:120]
aes_ready  in  1  core idle/done
aes_result  in  128  core output
key_valid  out  1  a key expansion has completed since reset
overrun  out  1  sticky; a byte arrived while it could not be accepted
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; byte counter 0; key and block registers 0. Reset mid-operation aborts everything, and no strobe follows release.
- Opcodes, the first byte of a frame:
  - 'K' (8'h4B) + 16 key bytes
  - 'L' (8'h4C) + 32 key bytes
  - 'E' (8'h45) + 16 data bytes
  - 'D' (8'h44) + 16 data bytes
  - Any other opcode: send NAK_BYTE, return to IDLE, no payload consumed.
- States: IDLE, COLLECT, AES_START, AES_WAIT_LO, AES_WAIT_HI, TX_LOAD, TX_PULSE, TX_WAIT.
- Collection: bytes fill MSB-first into the key or block register; the counter counts to 15 or 31. The last payload byte moves COLLECT to AES_START on the next cycle.
- K/L: in AES_START, wait for aes_ready=1, then pulse aes_init for one cycle with aes_keylen set. Wait for aes_ready=0, then aes_ready=1. Set key_valid and send ACK_BYTE.
- E/D:
  - key_valid=0: the payload is still consumed, then NAK_BYTE is sent.
  - Otherwise: pulse aes_next with aes_encdec set (E=1, D=0), run the same lo/hi wait, latch aes_result into the tx shift register, and send 16 bytes, [127:120] first.
- TX handshake:
  - TX_LOAD drives tx_data.
  - TX_PULSE asserts tx_start only when tx_busy=0.
  - TX_WAIT spends one guard cycle, then waits for tx_busy=0. It then advances to the next byte or returns to IDLE.
  - Never two tx_start within 2 cycles.
- Timeout: in COLLECT, a counter reloads on each rx_valid. At TIMEOUT_CLKS it discards the frame, sends TMO_BYTE and returns to IDLE.
- Overrun: rx_valid in any state other than IDLE/COLLECT sets overrun, and the byte is dropped. overrun is cleared only by reset.
- Simultaneous events: rx_valid on the same cycle as a timeout expiry means the byte is accepted and the timeout is cancelled.
- Key reload while key_valid=1: key_valid clears when aes_init pulses and sets again on completion.

Optional Feature:
AES_CBC_EN
- Defined:
  - Adds a 128-bit chain register, zeroed on reset and on each K/L completion.
  - Adds opcode 'I' (8'h49) + 16 bytes: loads the chain register, then sends ACK_BYTE.
  - E: aes_block = payload ^ chain; the ciphertext becomes the chain.
  - D: aes_block = payload; output = aes_result ^ chain; the payload becomes the chain.
- Undefined: 'I' is NAK'd and the mode is ECB; no chain register is synthesised.

Decomposition:
- Package uart_aes_pkg holds:
  - opcode constants (OP_KEY128, OP_KEY256, OP_ENC, OP_DEC, OP_IV)
  - the state enum
  - status byte defaults
- One natural sub-module: uart_aes_txser, a 16-byte shift register plus the TX handshake FSM (TX_LOAD/TX_PULSE/TX_WAIT), also used for single status bytes.

Test Plan:
- 'K' + 000102..0f, then 'E' + 00112233445566778899aabbccddeeff -> ACK 06, then 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- 'L' + 000102..1f, 'E' + same plaintext -> ACK, then 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89; 'D' of that ciphertext -> the plaintext.
- After reset, 'E' + 16 bytes -> single 15, aes_next never pulses; opcode 8'h5A -> single 15.
- 'K' + 5 bytes then silence (TIMEOUT_CLKS=100) -> 18 at ~100 clocks; the next 'K' frame is accepted normally.
- Byte injected during a 16-byte response -> overrun=1, response unchanged; reset during AES_WAIT_HI -> all outputs 0, no tx_start.
- AES_CBC_EN: 'I' + zeros, two identical 'E' blocks -> the two ciphertexts differ, and the second equals E(pt ^ ct1).
